// File: rtl/input_fetch_sequencer.sv
// input_fetch_sequencer
// Streams a job of `length` consecutive words, starting at `base_addr`, out of
// the input_buffer read port and onto a valid/ready stream. A 4-entry skid
// FIFO absorbs the two-cycle read latency (registered strobe + registered
// buffer data). Reads are throttled so the FIFO plus the reads in flight
// never exceed its capacity, even when the downstream stalls.
module input_fetch_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic        [ADDR_WIDTH-1:0] base_addr,
    input  logic        [ADDR_WIDTH:0]   length,
    output logic                         busy,
    output logic                         done,
    output logic                         buf_rd_en,
    output logic        [ADDR_WIDTH-1:0] buf_rd_addr,
    input  logic signed [DATA_WIDTH-1:0] buf_rd_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_last
);

    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Job bookkeeping: reads still to issue, words still to deliver.
    logic [ADDR_WIDTH:0]   reads_left;
    logic [ADDR_WIDTH:0]   out_left;
    logic [ADDR_WIDTH-1:0] next_addr;

    // Second stage of the read pipeline: buf_rd_data is valid this cycle.
    logic cap_valid;

    // Skid FIFO.
    logic signed [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;

    logic       push;
    logic       pop;
    logic       issue;
    logic       job_start;
    logic [3:0] occupancy;

    assign job_start = (state == IDLE) && start;
    assign push      = cap_valid;
    assign pop       = out_valid && out_ready;

    // Entries that will be held or still arriving after this edge; a
    // same-cycle pop frees its slot.
    assign occupancy = {1'b0, count} + {3'b000, cap_valid} + {3'b000, buf_rd_en}
                     - {3'b000, pop};

    assign issue = (state == FETCH) && (reads_left != '0)
                && (occupancy < 4'(FIFO_DEPTH));

    // Stream outputs come straight from the FIFO head; out_data is forced to
    // zero when empty so the un-reset storage never leaks onto the port.
    assign out_valid = (count != 3'd0);
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
    assign out_last  = out_valid && (out_left == {{ADDR_WIDTH{1'b0}}, 1'b1});

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of process order.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: leave FETCH once the final read is on the bus, and
    // DRAIN once the last word has been handed downstream.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch
        // is inferred.
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (length == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (buf_rd_en && (reads_left == '0)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read issue: registered strobe and address, address wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reads_left  <= '0;
            next_addr   <= '0;
            buf_rd_en   <= 1'b0;
            buf_rd_addr <= '0;
            cap_valid   <= 1'b0;
        end else begin
            buf_rd_en <= issue;
            cap_valid <= buf_rd_en;
            if (job_start) begin
                reads_left <= length;
                next_addr  <= base_addr;
            end else if (issue) begin
                reads_left  <= reads_left - 1'b1;
                next_addr   <= next_addr + 1'b1;
                buf_rd_addr <= next_addr;
            end
        end
    end

    // Delivered-word countdown that drives out_last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_left <= '0;
        end else if (job_start) begin
            out_left <= length;
        end else if (pop) begin
            out_left <= out_left - 1'b1;
        end
    end

    // FIFO pointers and fill level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {2'b00, push} - {2'b00, pop};
        end
    end

    // FIFO storage write; captures buf_rd_data the cycle after its strobe.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; count gates every read
        // of it, so its power-up contents are never observable.
        if (push) begin
            fifo_mem[wr_ptr] <= buf_rd_data;
        end
    end

endmodule

// File: tb/tb_input_fetch_sequencer.sv
// tb_input_fetch_sequencer
// Directed bench with a registered-read buffer model, a scoreboard queue of
// expected words (pushed at job start, popped on each accepted word) and a
// per-cycle monitor for stall stability, read throttling and timing.
`timescale 1ns/1ps
module tb_input_fetch_sequencer;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic        [AW-1:0] base_addr = '0;
    logic        [AW:0]   length = '0;
    logic                 busy;
    logic                 done;
    logic                 buf_rd_en;
    logic        [AW-1:0] buf_rd_addr;
    logic signed [DW-1:0] buf_rd_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [DW-1:0] out_data;
    logic                 out_last;

    input_fetch_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .buf_rd_en   (buf_rd_en),
        .buf_rd_addr (buf_rd_addr),
        .buf_rd_data (buf_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    // Input buffer model: registered read, data valid the cycle after strobe.
    logic signed [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];
    end

    typedef struct packed {
        logic signed [DW-1:0] data;
        logic                 last;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Downstream ready pattern: 0 = held by main sequence, 1 = toggle, 2 = random.
    int ready_mode = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       out_ready = ~out_ready;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: ;
            endcase
        end
    end

    // Monitor state.
    int cyc = 0;
    int pops, done_cnt, done_cyc, first_valid_cyc, first_pop_cyc, last_pop_cyc;
    int issued, accepted, rd_cycles, valid_cycles;
    logic [AW-1:0] addr_q[$];
    logic                 prev_stall = 1'b0;
    logic signed [DW-1:0] prev_data  = '0;
    logic                 prev_last  = 1'b0;

    task automatic reset_stats();
        pops = 0; done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
        first_pop_cyc = -1; last_pop_cyc = -1;
        issued = 0; accepted = 0; rd_cycles = 0; valid_cycles = 0;
        addr_q.delete();
    endtask

    // Per-cycle monitor, sampling mid-cycle on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (buf_rd_en) begin
                issued++;
                rd_cycles++;
                addr_q.push_back(buf_rd_addr);
                chk("outstanding_le4", 32'((issued - accepted) <= 4), 1);
                chk("rd_en_only_fetch", 32'(busy && !done), 1);
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_data", 32'(out_data), 32'(prev_data));
                chk("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid) begin
                valid_cycles++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                chk("word_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("word_data", 32'(out_data), 32'(e.data));
                    chk("word_last", 32'(out_last), 32'(e.last));
                end
                accepted++;
                pops++;
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic push_expected(input int base, input int len);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            e.data = mem[(base + i) % DEPTH];
            e.last = (i == len - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start(input int base, input int len);
        @(posedge clk);
        #1;
        base_addr = AW'(base);
        length    = (AW+1)'(len);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // One complete job: expectations, start, optional stray start, bounded wait.
    task automatic run_job(input int base, input int len, input bit extra_start, output int t0);
        int n;
        push_expected(base, len);
        reset_stats();
        pulse_start(base, len);
        t0 = cyc;
        if (extra_start) begin
            @(posedge clk);
            pulse_start(9, 3);
        end
        n = 0;
        while (done_cnt == 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_count", done_cnt, 1);
        chk("word_count", pops, len);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("idle_after_job", 32'(busy), 0);
    endtask

    task automatic check_addrs(input int base, input int len);
        logic [AW-1:0] a;
        chk("addr_count", addr_q.size(), len);
        for (int i = 0; i < len; i++) begin
            a = (i < addr_q.size()) ? addr_q[i] : 'x;
            chk("rd_addr", 32'(a), 32'((base + i) % DEPTH));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"},      32'(busy), 0);
        chk({tag, "_done"},      32'(done), 0);
        chk({tag, "_rd_en"},     32'(buf_rd_en), 0);
        chk({tag, "_rd_addr"},   32'(buf_rd_addr), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_last"},  32'(out_last), 0);
        chk({tag, "_out_data"},  32'(out_data), 0);
    endtask

    initial begin
        int t0;
        int n;
        int done_before;

        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 53 - 300);
        mem[0] = 16'sd5;
        mem[1] = -16'sd7;
        mem[2] = 16'sd11;
        mem[3] = 16'sd22;
        reset_stats();

        // Power-up reset.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Basic job, ready held high: latency, back-to-back words, done timing.
        out_ready = 1'b1;
        run_job(0, 4, 1'b0, t0);
        chk("first_valid_latency", first_valid_cyc, t0 + 4);
        chk("consecutive_words", last_pop_cyc - first_pop_cyc, 3);
        chk("done_after_last", done_cyc, last_pop_cyc + 1);
        check_addrs(0, 4);

        // Same job with ready toggling every cycle.
        ready_mode = 1;
        run_job(0, 4, 1'b0, t0);
        ready_mode = 0;
        out_ready  = 1'b1;
        check_addrs(0, 4);

        // Address wrap at the top of the buffer.
        run_job(DEPTH - 2, 4, 1'b0, t0);
        check_addrs(DEPTH - 2, 4);

        // Zero-length job: done the cycle after start, no reads, no words.
        run_job(3, 0, 1'b0, t0);
        chk("len0_done_cycle", done_cyc, t0 + 1);
        chk("len0_no_reads", rd_cycles, 0);
        chk("len0_no_valid", valid_cycles, 0);

        // Stray start during a job is ignored.
        run_job(0, 4, 1'b1, t0);
        check_addrs(0, 4);

        // Full-buffer job with random backpressure.
        ready_mode = 2;
        run_job(5, DEPTH, 1'b0, t0);
        ready_mode = 0;
        out_ready  = 1'b1;
        check_addrs(5, DEPTH);

        // Reset after the second word is accepted aborts the job.
        push_expected(0, 4);
        reset_stats();
        pulse_start(0, 4);
        n = 0;
        while (pops < 2 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("abort_two_words", pops, 2);
        done_before = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, done_before);
        rst_n = 1'b1;
        run_job(0, 2, 1'b0, t0);
        chk("post_reset_latency", first_valid_cyc, t0 + 4);
        check_addrs(0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
